// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared encodings and defaults for the MEM-stage access controller
package mips_mem_pkg;

  // mem_size encodings; 2'b11 falls through to word handling
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam int DEFAULT_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - req/ack data-bus bundle between the MEM stage and the data memory
interface mem_access_stage_if;

  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;

  modport master (
    output dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
    input  dbus_ack, dbus_rdata
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
    output dbus_ack, dbus_rdata
  );

endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - misalign check, store lane steering and load extract/extend
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [1:0]  addr_lo,
  input  logic        is_store,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic        misalign,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/half out of the little-endian read word
  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // Size-dependent alignment, byte enables, write replication and load extension
  always_comb begin
    misalign  = 1'b0;
    be        = 4'b1111;
    wdata     = store_data;
    load_data = rdata;
    case (mem_size)
      SIZE_B: begin
        if (is_store) be = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{~mem_unsigned & byte_sel[7]}}, byte_sel};
      end
      SIZE_H: begin
        misalign = addr_lo[0];
        if (is_store) be = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{store_data[15:0]}};
        load_data = {{16{~mem_unsigned & half_sel[15]}}, half_sel};
      end
      default: begin
        misalign = (addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM-stage load/store controller driving a req/ack data bus
module mem_access_stage
  import mips_mem_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic        regwrite_in,
  output logic        regwrite_out,
  output logic [31:0] mem_data,
  output logic        mem_stall,
  output logic        misalign,
  output logic        bus_err,
  mem_access_stage_if.master dbus
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  mem_state_e  state;
  logic [15:0] cnt;
  logic [31:0] rdata_q;
  logic        bus_err_q;
  logic        align_err;
  logic        access;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [31:0] load_data;

  mem_lane_align u_align (
    .mem_size     (mem_size),
    .mem_unsigned (mem_unsigned),
    .addr_lo      (addr[1:0]),
    .is_store     (mem_write),
    .store_data   (store_data),
    .rdata        (rdata_q),
    .misalign     (align_err),
    .be           (be_n),
    .wdata        (wdata_n),
    .load_data    (load_data)
  );

  // Stall covers the launch cycle and every REQ cycle; reset releases it immediately
  always_comb begin
    misalign     = (mem_read | mem_write) & align_err;
    access       = (mem_read | mem_write) & ~align_err;
    mem_stall    = ~rst & (((state == ST_IDLE) & access) | (state == ST_REQ));
    regwrite_out = regwrite_in & ~mem_stall;
    mem_data     = (state == ST_DONE) ? load_data : 32'h0;
    bus_err      = bus_err_q;
  end

  // Transaction FSM: launch from IDLE, wait for ack or timeout in REQ, hand off in DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      cnt             <= 16'h0;
      rdata_q         <= 32'h0;
      bus_err_q       <= 1'b0;
      dbus.dbus_req   <= 1'b0;
      dbus.dbus_we    <= 1'b0;
      dbus.dbus_addr  <= 32'h0;
      dbus.dbus_be    <= 4'h0;
      dbus.dbus_wdata <= 32'h0;
    end else begin
      bus_err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= 16'h0;
          if (access) begin
            dbus.dbus_req   <= 1'b1;
            dbus.dbus_we    <= mem_write;
            dbus.dbus_addr  <= {addr[31:2], 2'b00};
            dbus.dbus_be    <= be_n;
            dbus.dbus_wdata <= wdata_n;
            state           <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (dbus.dbus_ack) begin
            rdata_q       <= dbus.dbus_rdata;
            dbus.dbus_req <= 1'b0;
            state         <= ST_DONE;
          end else if (cnt == CNT_LAST) begin
            rdata_q       <= 32'h0;
            bus_err_q     <= 1'b1;
            dbus.dbus_req <= 1'b0;
            state         <= ST_DONE;
          end else begin
            cnt <= cnt + 16'h1;
          end
        end
        ST_DONE: begin
          cnt   <= 16'h0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - randomized self-checking bench for mem_access_stage
module tb_mem_access_stage;
  import mips_mem_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  mem_size = 2'b00;
  logic        mem_unsigned = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic        regwrite_in = 1'b0;
  logic        regwrite_out;
  logic [31:0] mem_data;
  logic        mem_stall;
  logic        misalign;
  logic        bus_err;

  int vectors = 0;
  int miscompares = 0;

  mem_access_stage_if bus ();

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_size     (mem_size),
    .mem_unsigned (mem_unsigned),
    .addr         (addr),
    .store_data   (store_data),
    .regwrite_in  (regwrite_in),
    .regwrite_out (regwrite_out),
    .mem_data     (mem_data),
    .mem_stall    (mem_stall),
    .misalign     (misalign),
    .bus_err      (bus_err),
    .dbus         (bus)
  );

  always #5 clk = ~clk;

  function automatic int nbytes(logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit m_misalign(logic [1:0] s, logic [31:0] a);
    return (int'(a[1:0]) % nbytes(s)) != 0;
  endfunction

  function automatic logic [3:0] m_be(bit wr, logic [1:0] s, logic [31:0] a);
    int lanes;
    if (!wr) return 4'hF;
    lanes = ((1 << nbytes(s)) - 1) << int'(a[1:0]);
    return lanes[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(logic [1:0] s, logic [31:0] d);
    if (nbytes(s) == 1) return (d & 32'hFF) * 32'h01010101;
    if (nbytes(s) == 2) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(logic [1:0] s, bit u, logic [31:0] a, logic [31:0] r);
    logic [31:0] v, mask;
    int n;
    n = nbytes(s);
    mask = (n == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * n)) - 32'd1);
    v = (r >> (8 * int'(a[1:0]))) & mask;
    if (!u && n < 4 && v[8 * n - 1]) v = v | ~mask;
    return v;
  endfunction

  // Runs one instruction through MEM; called at posedge+1 with the stage idle.
  // delay: REQ-cycle index at which ack is given, -1 for never.
  task automatic run_access(input bit wr, input logic [1:0] sz, input bit uns,
                            input logic [31:0] a, input logic [31:0] sd,
                            input logic [31:0] rd, input int delay, input string tag);
    bit mis, done, tmo;
    int stalls, reqc, exp_stall;
    logic [31:0] exp_md;
    mis = m_misalign(sz, a);
    tmo = (delay < 0);
    mem_read = !wr; mem_write = wr; mem_size = sz; mem_unsigned = uns;
    addr = a; store_data = sd; regwrite_in = !wr;
    bus.dbus_ack = 1'b0; bus.dbus_rdata = rd;
    #1;
    vectors++;
    if (misalign !== mis) begin miscompares++; $display("FAIL %s misalign: got %b want %b", tag, misalign, mis); end
    if (mis) begin
      vectors++;
      if (mem_stall !== 1'b0) begin miscompares++; $display("FAIL %s misalign_stall: got %b want 0", tag, mem_stall); end
      vectors++;
      if (mem_data !== 32'h0) begin miscompares++; $display("FAIL %s misalign_data: got %h want 0", tag, mem_data); end
      @(posedge clk); #1;
      vectors++;
      if (bus.dbus_req !== 1'b0) begin miscompares++; $display("FAIL %s misalign_req: got %b want 0", tag, bus.dbus_req); end
      mem_read = 1'b0; mem_write = 1'b0;
      return;
    end
    vectors++;
    if (mem_stall !== 1'b1 || regwrite_out !== 1'b0) begin
      miscompares++; $display("FAIL %s launch: stall %b rw %b want 1/0", tag, mem_stall, regwrite_out);
    end
    stalls = 1; reqc = 0; done = 0;
    for (int cyc = 0; cyc < 50 && !done; cyc++) begin
      @(posedge clk); #1;
      bus.dbus_ack = 1'b0;
      if (mem_stall) begin
        stalls++;
        if (reqc == 0) begin
          vectors++;
          if (bus.dbus_req !== 1'b1 || bus.dbus_we !== wr) begin
            miscompares++; $display("FAIL %s req_we: got %b/%b want 1/%b", tag, bus.dbus_req, bus.dbus_we, wr);
          end
          vectors++;
          if (bus.dbus_addr !== (a & 32'hFFFFFFFC)) begin
            miscompares++; $display("FAIL %s dbus_addr: got %h want %h", tag, bus.dbus_addr, a & 32'hFFFFFFFC);
          end
          vectors++;
          if (bus.dbus_be !== m_be(wr, sz, a)) begin
            miscompares++; $display("FAIL %s dbus_be: got %b want %b", tag, bus.dbus_be, m_be(wr, sz, a));
          end
          if (wr) begin
            vectors++;
            if (bus.dbus_wdata !== m_wdata(sz, sd)) begin
              miscompares++; $display("FAIL %s dbus_wdata: got %h want %h", tag, bus.dbus_wdata, m_wdata(sz, sd));
            end
          end
          vectors++;
          if (regwrite_out !== 1'b0) begin miscompares++; $display("FAIL %s rw_stalled: got %b want 0", tag, regwrite_out); end
        end
        if (reqc == delay) bus.dbus_ack = 1'b1;
        reqc++;
      end else begin
        done = 1;
        exp_stall = tmo ? 1 + TO : 2 + delay;
        exp_md = tmo ? 32'h0 : m_load(sz, uns, a, rd);
        vectors++;
        if (stalls !== exp_stall) begin miscompares++; $display("FAIL %s stall_cycles: got %0d want %0d", tag, stalls, exp_stall); end
        vectors++;
        if (bus.dbus_req !== 1'b0) begin miscompares++; $display("FAIL %s done_req: got %b want 0", tag, bus.dbus_req); end
        vectors++;
        if (bus_err !== tmo) begin miscompares++; $display("FAIL %s bus_err: got %b want %b", tag, bus_err, tmo); end
        vectors++;
        if (regwrite_out !== regwrite_in) begin miscompares++; $display("FAIL %s done_rw: got %b want %b", tag, regwrite_out, regwrite_in); end
        if (!wr) begin
          vectors++;
          if (mem_data !== exp_md) begin miscompares++; $display("FAIL %s mem_data: got %h want %h", tag, mem_data, exp_md); end
        end
      end
    end
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL %s no_done: stall still %b after 50 cycles, want release", tag, mem_stall);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus_err !== 1'b0 || mem_data !== 32'h0) begin
      miscompares++; $display("FAIL %s after_done: err %b data %h want 0/0", tag, bus_err, mem_data);
    end
    mem_read = 1'b0; mem_write = 1'b0; bus.dbus_ack = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if (bus.dbus_req !== 1'b0 || bus.dbus_we !== 1'b0) begin
      miscompares++; $display("FAIL reset_req_we: got %b/%b want 0/0", bus.dbus_req, bus.dbus_we);
    end
    vectors++;
    if (bus.dbus_addr !== 32'h0 || bus.dbus_be !== 4'h0 || bus.dbus_wdata !== 32'h0) begin
      miscompares++; $display("FAIL reset_bus: addr %h be %b wdata %h want 0", bus.dbus_addr, bus.dbus_be, bus.dbus_wdata);
    end
    vectors++;
    if (mem_stall !== 1'b0 || mem_data !== 32'h0 || bus_err !== 1'b0 || misalign !== 1'b0) begin
      miscompares++; $display("FAIL reset_outs: stall %b data %h err %b mis %b want 0", mem_stall, mem_data, bus_err, misalign);
    end
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_nonmem();
    mem_read = 1'b0; mem_write = 1'b0; regwrite_in = 1'b1; addr = 32'h103;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (mem_stall !== 1'b0 || regwrite_out !== 1'b1 || bus.dbus_req !== 1'b0) begin
        miscompares++; $display("FAIL nonmem: stall %b rw %b req %b want 0/1/0", mem_stall, regwrite_out, bus.dbus_req);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_directed();
    run_access(1'b0, SIZE_W, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, "lw");
    run_access(1'b0, SIZE_B, 1'b0, 32'h103, 32'h0, 32'h80112233, 0, "lb");
    run_access(1'b0, SIZE_B, 1'b1, 32'h103, 32'h0, 32'h80112233, 1, "lbu");
    run_access(1'b1, SIZE_H, 1'b0, 32'h206, 32'h1234ABCD, 32'h0, 0, "sh");
    run_access(1'b0, SIZE_H, 1'b0, 32'h102, 32'h0, 32'h8001FFFF, TO - 1, "lh_last_cycle");
  endtask

  task automatic test_misalign();
    run_access(1'b0, SIZE_W, 1'b0, 32'h102, 32'h0, 32'h12345678, 0, "lw_mis");
    run_access(1'b1, SIZE_H, 1'b0, 32'h301, 32'hAAAA5555, 32'h0, 0, "sh_mis");
    run_access(1'b0, 2'b11, 1'b0, 32'h401, 32'h0, 32'h0, 0, "size3_mis");
  endtask

  task automatic test_timeout();
    run_access(1'b0, SIZE_W, 1'b0, 32'h500, 32'h0, 32'hCAFEF00D, -1, "timeout");
  endtask

  task automatic test_reset_mid_req();
    mem_read = 1'b1; mem_write = 1'b0; mem_size = SIZE_W; addr = 32'h300; regwrite_in = 1'b1;
    bus.dbus_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    vectors++;
    if (bus.dbus_req !== 1'b1 || mem_stall !== 1'b1) begin
      miscompares++; $display("FAIL rst_mid_pre: req %b stall %b want 1/1", bus.dbus_req, mem_stall);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (bus.dbus_req !== 1'b0 || mem_stall !== 1'b0) begin
      miscompares++; $display("FAIL rst_mid_drop: req %b stall %b want 0/0", bus.dbus_req, mem_stall);
    end
    mem_read = 1'b0;
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    run_access(1'b0, SIZE_W, 1'b0, 32'h304, 32'h0, 32'h0BADC0DE, 0, "b2b_1");
    run_access(1'b0, SIZE_H, 1'b1, 32'h30A, 32'h0, 32'hF00D1234, 2, "b2b_2");
  endtask

  task automatic test_random();
    bit wr, uns;
    logic [1:0] sz;
    logic [31:0] a, sd, rd;
    int delay;
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(nbytes(sz)) - 32'd1);
      sd = $urandom;
      rd = $urandom;
      delay = $urandom_range(0, TO - 1);
      if ($urandom_range(0, 9) == 0) delay = -1;
      run_access(wr, sz, uns, a, sd, rd, delay, "rand");
    end
  endtask

  initial begin
    bus.dbus_ack = 1'b0;
    bus.dbus_rdata = 32'h0;
    test_reset();
    test_nonmem();
    test_directed();
    test_misalign();
    test_timeout();
    test_reset_mid_req();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

MEM-stage data-memory access controller for the 5-stage MIPS pipeline. It sits between the EX/MEM latches and the MEM/WB latches. It turns load/store requests into a req/ack data-bus transaction, performing byte-lane alignment and load extension. While a transaction is outstanding it stalls the upstream pipeline and injects a bubble (RegWrite gated) into MEM/WB.

## Interface
- `TIMEOUT`, default 255: maximum cycles spent in REQ waiting for `dbus_ack` before aborting with `bus_err`.
- `clk`, input, 1: clock.
- `rst`, input, 1: reset, asynchronous, active-high.
- `mem_read`, input, 1: EX/MEM load request.
- `mem_write`, input, 1: EX/MEM store request.
- `mem_size`, input, 2: 00 byte, 01 half, 10 word; 11 is treated as word.
- `mem_unsigned`, input, 1: zero-extend loads (lbu/lhu) when 1; sign-extend when 0.
- `addr`, input, 32: byte address (ALU result).
- `store_data`, input, 32: rt value; the low byte/half is used for narrow stores.
- `regwrite_in`, input, 1: EX/MEM RegWrite.
- `regwrite_out`, output, 1: `regwrite_in & ~mem_stall`; drives `MEM_RegWrite`.
- `mem_data`, output, 32: aligned, extended load data; drives `MEM_MemData`.
- `mem_stall`, output, 1: holds PC, IF/ID, ID/EX and EX/MEM.
- `misalign`, output, 1: combinational misaligned-access flag.
- `bus_err`, output, 1: one-cycle pulse on timeout.
- `dbus_req`, output, 1: bus request, registered.
- `dbus_we`, output, 1: bus write enable, registered.
- `dbus_addr`, output, 32: `{addr[31:2],2'b00}`, registered.
- `dbus_be`, output, 4: byte enables, registered.
- `dbus_wdata`, output, 32: write data, registered.
- `dbus_ack`, input, 1: transaction complete.
- `dbus_rdata`, input, 32: read data, valid in the `dbus_ack` cycle.

## Operation
- Access is `(mem_read|mem_write) & ~misalign`.
- Misalign conditions: half with `addr[0]`; word with `addr[1:0]!=0`. A byte access is never misaligned.
- FSM states are IDLE, REQ and DONE.
- **IDLE:** on access, latch the bus outputs, go to REQ, and assert `mem_stall`=1 combinationally. Otherwise `mem_stall`=0 and the state stays IDLE.
- **REQ:** `dbus_req`=1, `mem_stall`=1, bus outputs held stable, and the timeout counter increments.
  - On `dbus_ack`: `rdata_q<=dbus_rdata`, go to DONE.
  - When the counter reaches `TIMEOUT` without ack: `rdata_q<=0`, pulse `bus_err`, go to DONE.
- **DONE:** `mem_stall`=0 and `dbus_req`=0. MEM/WB captures at the end of this cycle. Next state is IDLE and the counter clears.
- `dbus_ack` outside REQ is ignored.
- Misaligned access: no bus transaction, `mem_stall`=0, store suppressed, `mem_data`=0, `misalign`=1 for as long as the inputs persist.
- Store lanes (little-endian):
  - byte: `be`=`4'b0001<<addr[1:0]`, wdata = `store_data[7:0]` replicated ×4.
  - half: `be` = `addr[1]` ? 1100 : 0011, wdata = `store_data[15:0]` replicated ×2.
  - word: `be`=1111, wdata = `store_data`.
  - Loads use `be`=1111.
- Load extract from `rdata_q`:
  - byte: lane `addr[1:0]`, extended to 32.
  - half: lane `addr[1]`, extended.
  - word: passed through.
  - Extension is sign or zero per `mem_unsigned`.
- `mem_data` is combinational from `rdata_q` and `addr`, and is 0 in any cycle where the state is not DONE.

## Timing
- Minimum load/store latency is 3 cycles in MEM (2 stall cycles), when ack arrives in the first REQ cycle.
- Each extra wait cycle of `dbus_ack` adds one stall cycle.
- Timeout path: stall cycles = 1 + `TIMEOUT`.
- Non-memory instructions pass with zero stall.
- Reset values: state IDLE, `dbus_req`/`dbus_we`=0, `dbus_addr`/`dbus_be`/`dbus_wdata`=0, `rdata_q`=0, counter 0, `bus_err`=0. Consequently `mem_stall`=0 (given no request) and `mem_data`=0.
- Reset mid-REQ aborts immediately: `dbus_req` drops asynchronously, and the bus slave must tolerate the withdrawn request.
- `addr`, `mem_size` and `mem_unsigned` are stable throughout stall because EX/MEM is held.

## Structure
- Package `mips_mem_pkg` holds:
  - the size encodings (`SIZE_B`, `SIZE_H`, `SIZE_W`);
  - the FSM state enum (IDLE/REQ/DONE);
  - the default `TIMEOUT`.
- Sub-module `mem_lane_align` (combinational) covers the misalign check, store `be`/wdata generation, and load extract/extend. The top level holds the FSM, registers and counter.

## Test plan
- **Word load, ack in first REQ cycle:** `addr`=0x100, `rdata`=0xDEADBEEF → stall high for 2 cycles, `dbus_addr`=0x100, `be`=1111, `mem_data`=0xDEADBEEF in DONE, `regwrite_out` low while stalled.
- **lb vs lbu:** `addr`=0x103, `rdata`=0x80112233 → lb gives 0xFFFFFF80, lbu gives 0x00000080.
- **sh at `addr`=0x206, `store_data`=0x1234ABCD:** `dbus_addr`=0x204, `be`=1100, `wdata`=0xABCDABCD, `we`=1.
- **Misaligned lw at 0x102:** `misalign`=1, no `dbus_req`, stall 0, `mem_data`=0.
- **`TIMEOUT`=4, ack never arrives:** stall for 5 cycles, then a `bus_err` pulse, `mem_data`=0, return to IDLE.
- **`rst` asserted in the 2nd REQ cycle:** `dbus_req` and `mem_stall` drop without waiting for a clock edge. After release, a back-to-back load completes normally.
